// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment table for the
// seven-segment scan driver.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit6 = g ... bit0 = a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_BLANK;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble to active-low segment lookup.
module seven_seg_hex_decode (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);
    import seven_seg_pkg::*;

    assign seg_n_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan of a common-anode display with
// tear-free shadow registers and inter-digit blanking.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_W      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [NUM_DIGITS-1:0]   dp_mask_i,
    input  logic                    enable_i,
    input  logic [DIV_W-1:0]        scan_div_i,
    input  logic                    update_i,
    output logic                    update_pending_o,
    output logic [NUM_DIGITS-1:0]   an_n_o,
    output logic [6:0]              seg_n_o,
    output logic                    dp_n_o,
    output logic                    frame_done_o
);
    import seven_seg_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? DIV_W'(GAP_CYCLES - 1) : '0;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic                    abort_q, abort_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    logic                    load_win;
    logic                    gap_end;
    logic                    wrap;
    logic [3:0]              nib_sel;
    logic [6:0]              dec_seg;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        fd_d     = 1'b0;
        load_win = 1'b0;
        gap_end  = 1'b0;
        wrap     = 1'b0;

        unique case (state_q)
            IDLE: begin
                load_win = 1'b1;
                if (enable_i) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = scan_div_i;
                end
            end
            DRIVE: begin
                if (!enable_i || cnt_q == '0) begin
                    abort_d = !enable_i;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        gap_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) gap_end = 1'b1;
                else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // An aborted slot never completes the frame
        if (gap_end) begin
            if (abort_d) begin
                state_d = IDLE;
                idx_d   = '0;
                abort_d = 1'b0;
            end else begin
                wrap     = (idx_q == LAST_IDX);
                idx_d    = wrap ? '0 : idx_q + 1'b1;
                fd_d     = wrap;
                load_win = wrap;
                if (enable_i) begin
                    state_d = DRIVE;
                    cnt_d   = scan_div_i;
                end else begin
                    state_d = IDLE;
                end
            end
        end

        sh_val_d  = sh_val_q;
        sh_en_d   = sh_en_q;
        sh_dp_d   = sh_dp_q;
        pending_d = pending_q;
        if (load_win && (pending_q || update_i)) begin
            sh_val_d  = value_i;
            sh_en_d   = digit_en_i;
            sh_dp_d   = dp_mask_i;
            pending_d = 1'b0;
        end else if (update_i) begin
            pending_d = 1'b1;
        end
    end

    assign nib_sel = sh_val_d[idx_d*4 +: 4];

    seven_seg_hex_decode u_dec (
        .nibble_i (nib_sel),
        .seg_n_o  (dec_seg)
    );

    // Outputs follow the next state so they change with it
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_d == DRIVE) begin
            an_d  = ~(sh_en_d & (NUM_DIGITS'(1) << idx_d));
            seg_d = dec_seg;
            dp_d  = ~sh_dp_d[idx_d];
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            pending_q <= 1'b0;
            sh_val_q  <= '0;
            sh_en_q   <= '0;
            sh_dp_q   <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            pending_q <= pending_d;
            sh_val_q  <= sh_val_d;
            sh_en_q   <= sh_en_d;
            sh_dp_q   <= sh_dp_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign an_n_o           = an_q;
    assign seg_n_o          = seg_q;
    assign dp_n_o           = dp_q;
    assign frame_done_o     = fd_q;
    assign update_pending_o = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed, table-driven bench for the seven-segment
// scan driver (8 digits, 4-cycle on-time, 2-cycle gap).
module tb_seven_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [31:0] value_i;
    logic [7:0]  digit_en_i;
    logic [7:0]  dp_mask_i;
    logic        enable_i;
    logic [15:0] scan_div_i;
    logic        update_i;
    logic        update_pending_o;
    logic [7:0]  an_n_o;
    logic [6:0]  seg_n_o;
    logic        dp_n_o;
    logic        frame_done_o;

    int checks   = 0;
    int failures = 0;
    logic pend_exp = 1'b0;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp_n;
    } vec_t;

    vec_t vt [24];

    seven_seg_scan_driver #(
        .NUM_DIGITS (8),
        .DIV_W      (16),
        .GAP_CYCLES (2)
    ) dut (
        .s00_axi_aclk     (clk),
        .s00_axi_aresetn  (rst_n),
        .value_i          (value_i),
        .digit_en_i       (digit_en_i),
        .dp_mask_i        (dp_mask_i),
        .enable_i         (enable_i),
        .scan_div_i       (scan_div_i),
        .update_i         (update_i),
        .update_pending_o (update_pending_o),
        .an_n_o           (an_n_o),
        .seg_n_o          (seg_n_o),
        .dp_n_o           (dp_n_o),
        .frame_done_o     (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_blank(input string nm);
        chk({nm, ".an"}, 32'(an_n_o), 32'hFF);
        chk({nm, ".seg"}, 32'(seg_n_o), 32'h7F);
        chk({nm, ".dp"}, 32'(dp_n_o), 32'h1);
    endtask

    // One full frame; optionally requests a shadow load mid-frame
    task automatic run_frame(input int base, input bit fd_first,
                             input int upd_d, input logic [31:0] nv,
                             input logic [7:0] nen, input logic [7:0] ndp);
        string tag;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 6; c++) begin
                tag = $sformatf("f%0d.d%0d.c%0d", base, d, c);
                if (c < 4) begin
                    chk({tag, ".an"}, 32'(an_n_o), 32'(vt[base+d].an));
                    chk({tag, ".seg"}, 32'(seg_n_o), 32'(vt[base+d].seg));
                    chk({tag, ".dp"}, 32'(dp_n_o), 32'(vt[base+d].dp_n));
                end else begin
                    chk_blank(tag);
                end
                chk({tag, ".fd"}, 32'(frame_done_o),
                    32'(fd_first && d == 0 && c == 0));
                chk({tag, ".pend"}, 32'(update_pending_o), 32'(pend_exp));
                if (d == upd_d && c == 0) begin
                    value_i    = nv;
                    digit_en_i = nen;
                    dp_mask_i  = ndp;
                    update_i   = 1'b1;
                end
                tick();
                if (update_i) begin
                    update_i = 1'b0;
                    pend_exp = 1'b1;
                end
            end
        end
        pend_exp = 1'b0;
    endtask

    initial begin
        // Frame A: 76543210, all enabled, no dp
        vt[0]  = '{8'hFE, 7'h40, 1'b1};
        vt[1]  = '{8'hFD, 7'h79, 1'b1};
        vt[2]  = '{8'hFB, 7'h24, 1'b1};
        vt[3]  = '{8'hF7, 7'h30, 1'b1};
        vt[4]  = '{8'hEF, 7'h19, 1'b1};
        vt[5]  = '{8'hDF, 7'h12, 1'b1};
        vt[6]  = '{8'hBF, 7'h02, 1'b1};
        vt[7]  = '{8'h7F, 7'h78, 1'b1};
        // Frame B: FFFFFFFF, all enabled
        vt[8]  = '{8'hFE, 7'h0E, 1'b1};
        vt[9]  = '{8'hFD, 7'h0E, 1'b1};
        vt[10] = '{8'hFB, 7'h0E, 1'b1};
        vt[11] = '{8'hF7, 7'h0E, 1'b1};
        vt[12] = '{8'hEF, 7'h0E, 1'b1};
        vt[13] = '{8'hDF, 7'h0E, 1'b1};
        vt[14] = '{8'hBF, 7'h0E, 1'b1};
        vt[15] = '{8'h7F, 7'h0E, 1'b1};
        // Frame C: FFFFFFFF, en=0F, dp=01
        vt[16] = '{8'hFE, 7'h0E, 1'b0};
        vt[17] = '{8'hFD, 7'h0E, 1'b1};
        vt[18] = '{8'hFB, 7'h0E, 1'b1};
        vt[19] = '{8'hF7, 7'h0E, 1'b1};
        vt[20] = '{8'hFF, 7'h0E, 1'b1};
        vt[21] = '{8'hFF, 7'h0E, 1'b1};
        vt[22] = '{8'hFF, 7'h0E, 1'b1};
        vt[23] = '{8'hFF, 7'h0E, 1'b1};

        rst_n      = 1'b0;
        enable_i   = 1'b1;
        value_i    = 32'h76543210;
        digit_en_i = 8'hFF;
        dp_mask_i  = 8'h00;
        scan_div_i = 16'd3;
        update_i   = 1'b0;

        tick();
        tick();
        chk_blank("reset");
        chk("reset.fd", 32'(frame_done_o), 32'h0);
        chk("reset.pend", 32'(update_pending_o), 32'h0);

        enable_i = 1'b0;
        rst_n    = 1'b1;
        tick();
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        chk("idle_load.pend", 32'(update_pending_o), 32'h0);
        chk_blank("idle");
        enable_i = 1'b1;
        tick();

        run_frame(0, 1'b0, -1, 32'h0, 8'h0, 8'h0);
        run_frame(0, 1'b1, 3, 32'hFFFFFFFF, 8'hFF, 8'h00);
        run_frame(8, 1'b1, 2, 32'hFFFFFFFF, 8'h0F, 8'h01);
        run_frame(16, 1'b1, 2, 32'h76543210, 8'hFF, 8'h00);

        // Enable drop in cycle 2 of digit 5
        chk("drop.d0.an", 32'(an_n_o), 32'hFE);
        chk("drop.d0.fd", 32'(frame_done_o), 32'h1);
        for (int i = 0; i < 30; i++) tick();
        chk("drop.d5c0.an", 32'(an_n_o), 32'hDF);
        chk("drop.d5c0.seg", 32'(seg_n_o), 32'h12);
        tick();
        tick();
        chk("drop.d5c2.an", 32'(an_n_o), 32'hDF);
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_blank($sformatf("drop.off%0d", i));
            chk($sformatf("drop.off%0d.fd", i), 32'(frame_done_o), 32'h0);
        end
        enable_i = 1'b1;
        tick();
        chk("reen.an", 32'(an_n_o), 32'hFE);
        chk("reen.seg", 32'(seg_n_o), 32'h40);
        chk("reen.fd", 32'(frame_done_o), 32'h0);

        // Async reset between edges with an update pending
        tick();
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        chk("arst.pend_before", 32'(update_pending_o), 32'h1);
        chk("arst.an_before", 32'(an_n_o), 32'hFE);
        #2;
        rst_n = 1'b0;
        #1;
        chk_blank("arst");
        chk("arst.pend", 32'(update_pending_o), 32'h0);
        chk("arst.fd", 32'(frame_done_o), 32'h0);
        enable_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_blank($sformatf("post_rst%0d", i));
            chk($sformatf("post_rst%0d.pend", i),
                32'(update_pending_o), 32'h0);
        end
        enable_i = 1'b1;
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        chk("restart.an", 32'(an_n_o), 32'hFE);
        chk("restart.seg", 32'(seg_n_o), 32'h40);
        chk("restart.dp", 32'(dp_n_o), 32'h1);
        chk("restart.pend", 32'(update_pending_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
